layer_scheduler: RTL and testbench

Sequences one fully-connected layer through the accelerator datapath (16-lane parallel multiplier, accumulation register, ReLU). For each output neuron it walks all 16-neuron input tiles: it issues the BRAM input-tile read, requests the matching weight word from SRAM, strobes the PE for one MAC, closes the neuron, and writes the ReLU result back to BRAM. It sits between the CPU-facing configuration registers and the datapath, replacing ad-hoc sequencing in the accelerator top level.

---
 rtl/layer_scheduler_pkg.sv | 19 +
 rtl/layer_counters.sv | 64 ++++++
 rtl/layer_scheduler.sv | 136 +++++++++++++
 tb/tb_layer_scheduler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/layer_scheduler_pkg.sv
// Shared types and constants for the fully-connected layer scheduler.
package layer_scheduler_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 16;
  localparam int unsigned ST_W           = 4;

  typedef enum logic [ST_W-1:0] {
    StIdle  = 4'd0,
    StFetch = 4'd1,
    StWaitW = 4'd2,
    StMac   = 4'd3,
    StNext  = 4'd4,
    StClose = 4'd5,
    StWaitR = 4'd6,
    StWrite = 4'd7,
    StFin   = 4'd8
  } state_e;

endpackage

// File: rtl/layer_counters.sv
// Tile, neuron and weight-pointer counters with latched layer sizes and terminal-count flags.
module layer_counters
  import layer_scheduler_pkg::*;
#(
  parameter int unsigned AddrW = ADDR_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [AddrW-1:0] i_wp_base,
  input  logic [AddrW-1:0] i_num_tiles,
  input  logic [AddrW-1:0] i_num_neurons,
  input  logic             i_t_step,
  input  logic             i_n_step,
  input  logic             i_wp_step,
  output logic [AddrW-1:0] o_t,
  output logic [AddrW-1:0] o_n,
  output logic [AddrW-1:0] o_wp,
  output logic             o_t_last,
  output logic             o_n_last
);

  localparam logic [AddrW-1:0] One = AddrW'(1);

  logic [AddrW-1:0] r_t;
  logic [AddrW-1:0] r_n;
  logic [AddrW-1:0] r_wp;
  logic [AddrW-1:0] r_num_tiles;
  logic [AddrW-1:0] r_num_neurons;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_t           <= '0;
      r_n           <= '0;
      r_wp          <= '0;
      r_num_tiles   <= '0;
      r_num_neurons <= '0;
    end else if (i_load) begin
      r_t           <= '0;
      r_n           <= '0;
      r_wp          <= i_wp_base;
      r_num_tiles   <= i_num_tiles;
      r_num_neurons <= i_num_neurons;
    end else begin
      if (i_t_step) begin
        r_t <= o_t_last ? '0 : r_t + One;
      end
      if (i_n_step) begin
        r_n <= r_n + One;
      end
      // Weights are stored contiguously, so the pointer simply walks forward.
      if (i_wp_step) begin
        r_wp <= r_wp + One;
      end
    end
  end

  assign o_t      = r_t;
  assign o_n      = r_n;
  assign o_wp     = r_wp;
  assign o_t_last = (r_t == r_num_tiles - One);
  assign o_n_last = (r_n == r_num_neurons - One);

endmodule

// File: rtl/layer_scheduler.sv
// Sequences one fully-connected layer: per neuron, fetch every input tile and weight word,
// MAC each one, close the accumulation and write the ReLU result back.
module layer_scheduler
  import layer_scheduler_pkg::*;
#(
  parameter int unsigned AddrW = ADDR_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [AddrW-1:0] i_in_base,
  input  logic [AddrW-1:0] i_out_base,
  input  logic [AddrW-1:0] i_w_base,
  input  logic [AddrW-1:0] i_num_tiles,
  input  logic [AddrW-1:0] i_num_neurons,
  input  logic             i_dval,
  input  logic             i_relu_valid,
  output logic             o_bram_rd,
  output logic [AddrW-1:0] o_bram_rd_addr,
  output logic             o_sram_rd_req,
  output logic [AddrW-1:0] o_sram_addr,
  output logic             o_pe_en,
  output logic             o_neuron_done,
  output logic             o_bram_wr,
  output logic [AddrW-1:0] o_bram_wr_addr,
  output logic             o_busy,
  output logic             o_done
);

  state_e           r_state;
  state_e           w_state_d;
  logic [AddrW-1:0] r_in_base;
  logic [AddrW-1:0] r_out_base;

  logic             w_load;
  logic             w_t_step;
  logic             w_n_step;
  logic             w_wp_step;
  logic [AddrW-1:0] w_t;
  logic [AddrW-1:0] w_n;
  logic [AddrW-1:0] w_wp;
  logic             w_t_last;
  logic             w_n_last;

  layer_counters #(
    .AddrW(AddrW)
  ) u_counters (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_load       (w_load),
    .i_wp_base    (i_w_base),
    .i_num_tiles  (i_num_tiles),
    .i_num_neurons(i_num_neurons),
    .i_t_step     (w_t_step),
    .i_n_step     (w_n_step),
    .i_wp_step    (w_wp_step),
    .o_t          (w_t),
    .o_n          (w_n),
    .o_wp         (w_wp),
    .o_t_last     (w_t_last),
    .o_n_last     (w_n_last)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state    <= StIdle;
      r_in_base  <= '0;
      r_out_base <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_load) begin
        r_in_base  <= i_in_base;
        r_out_base <= i_out_base;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_load    = 1'b0;
    w_t_step  = 1'b0;
    w_n_step  = 1'b0;
    w_wp_step = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_load    = 1'b1;
          w_state_d = (i_num_tiles == '0 || i_num_neurons == '0) ? StFin : StFetch;
        end
      end
      StFetch: w_state_d = StWaitW;
      StWaitW: begin
        if (i_dval) begin
          w_state_d = StMac;
        end
      end
      StMac: begin
        w_wp_step = 1'b1;
        w_state_d = StNext;
      end
      StNext: begin
        w_t_step  = 1'b1;
        w_state_d = w_t_last ? StClose : StFetch;
      end
      StClose: w_state_d = StWaitR;
      StWaitR: begin
        if (i_relu_valid) begin
          w_state_d = StWrite;
        end
      end
      StWrite: begin
        if (w_n_last) begin
          w_state_d = StFin;
        end else begin
          w_n_step  = 1'b1;
          w_state_d = StFetch;
        end
      end
      StFin:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs decode the registered state only; addresses read as zero outside their strobes.
  assign o_bram_rd      = (r_state == StFetch);
  assign o_bram_rd_addr = o_bram_rd ? r_in_base + w_t : '0;
  assign o_sram_rd_req  = (r_state == StFetch) || (r_state == StWaitW);
  assign o_sram_addr    = o_sram_rd_req ? w_wp : '0;
  assign o_pe_en        = (r_state == StMac);
  assign o_neuron_done  = (r_state == StClose);
  assign o_bram_wr      = (r_state == StWrite);
  assign o_bram_wr_addr = o_bram_wr ? r_out_base + w_n : '0;
  assign o_busy         = (r_state != StIdle);
  assign o_done         = (r_state == StFin);

endmodule

// File: tb/tb_layer_scheduler.sv
// Self-checking bench: a transaction-level layer model feeds expected address queues and
// cycle budgets; a per-cycle monitor compares the DUT against them.
module tb_layer_scheduler;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic [15:0] i_in_base = '0, i_out_base = '0, i_w_base = '0;
  logic [15:0] i_num_tiles = '0, i_num_neurons = '0;
  logic        i_dval = 1'b0, i_relu_valid = 1'b0;
  logic        o_bram_rd, o_sram_rd_req, o_pe_en, o_neuron_done, o_bram_wr, o_busy, o_done;
  logic [15:0] o_bram_rd_addr, o_sram_addr, o_bram_wr_addr;

  layer_scheduler #(
    .AddrW(16)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_in_base     (i_in_base),
    .i_out_base    (i_out_base),
    .i_w_base      (i_w_base),
    .i_num_tiles   (i_num_tiles),
    .i_num_neurons (i_num_neurons),
    .i_dval        (i_dval),
    .i_relu_valid  (i_relu_valid),
    .o_bram_rd     (o_bram_rd),
    .o_bram_rd_addr(o_bram_rd_addr),
    .o_sram_rd_req (o_sram_rd_req),
    .o_sram_addr   (o_sram_addr),
    .o_pe_en       (o_pe_en),
    .o_neuron_done (o_neuron_done),
    .o_bram_wr     (o_bram_wr),
    .o_bram_wr_addr(o_bram_wr_addr),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected transactions and budgets, plus observed logs for literal checks.
  logic [15:0] q_rd[$], q_sram[$], q_wr[$];
  logic [15:0] obs_rd[$], obs_wr[$];
  int exp_pe, exp_nd, exp_busy;
  int pe_cnt, nd_cnt, done_cnt, busy_cyc;
  int kw = 1, rw = 1;
  bit relu_block = 1'b0;
  bit mon_en = 1'b0;

  task automatic build_expect(input logic [15:0] ib, ob, wb, input int nt, nn, k, r);
    logic [15:0] a;
    q_rd.delete(); q_sram.delete(); q_wr.delete(); obs_rd.delete(); obs_wr.delete();
    pe_cnt = 0; nd_cnt = 0; done_cnt = 0; busy_cyc = 0;
    for (int n = 0; n < nn && nt > 0; n++) begin
      for (int t = 0; t < nt; t++) begin
        a = ib + 16'(t);
        q_rd.push_back(a);
        a = wb + 16'(n * nt + t);
        q_sram.push_back(a);
      end
      a = ob + 16'(n);
      q_wr.push_back(a);
    end
    exp_pe   = (nt == 0 || nn == 0) ? 0 : nt * nn;
    exp_nd   = (nt == 0 || nn == 0) ? 0 : nn;
    exp_busy = (nt == 0 || nn == 0) ? 1 : nn * (nt * (3 + k) + 2 + r) + 1;
  endtask

  // SRAM and ReLU responders: dval k cycles after the request rises, relu_valid r after close.
  initial begin
    int dcnt, rcnt;
    dcnt = 0; rcnt = 0;
    forever begin
      @(posedge i_clk); #1;
      if (o_sram_rd_req) dcnt++; else dcnt = 0;
      i_dval = o_sram_rd_req && (dcnt == kw + 1);
      if (o_neuron_done) rcnt = 1; else if (rcnt != 0) rcnt++;
      i_relu_valid = (rcnt == rw + 1) && !relu_block;
      if (rcnt == rw + 1) rcnt = 0;
    end
  end

  bit prev_req = 1'b0, prev_dval = 1'b0;
  logic [15:0] cur_sram = '0;

  always @(negedge i_clk) begin
    if (mon_en) begin
      check("pe_en after dval", o_pe_en, prev_req && prev_dval);
      check("req drop after dval", o_sram_rd_req && prev_req && prev_dval, 0);
      check("bram_rd on req rise", o_bram_rd, o_sram_rd_req && !prev_req);
      if (o_bram_rd) begin
        obs_rd.push_back(o_bram_rd_addr);
        check("bram_rd expected", q_rd.size() > 0, 1);
        if (q_rd.size() > 0) check("bram_rd_addr", o_bram_rd_addr, q_rd.pop_front());
      end
      if (o_sram_rd_req && !prev_req) begin
        check("sram req expected", q_sram.size() > 0, 1);
        if (q_sram.size() > 0) cur_sram = q_sram.pop_front();
      end
      if (o_sram_rd_req) check("sram_addr", o_sram_addr, cur_sram);
      if (o_bram_wr) begin
        obs_wr.push_back(o_bram_wr_addr);
        check("bram_wr expected", q_wr.size() > 0, 1);
        if (q_wr.size() > 0) check("bram_wr_addr", o_bram_wr_addr, q_wr.pop_front());
      end
      if (o_pe_en) pe_cnt++;
      if (o_neuron_done) nd_cnt++;
      if (o_done) done_cnt++;
      if (o_busy) busy_cyc++;
    end
    prev_req  = o_sram_rd_req;
    prev_dval = i_dval;
  end

  task automatic run_layer(input logic [15:0] ib, ob, wb, nt, nn, input int k, r, poke_at);
    kw = k; rw = r;
    build_expect(ib, ob, wb, int'(nt), int'(nn), k, r);
    i_in_base = ib; i_out_base = ob; i_w_base = wb; i_num_tiles = nt; i_num_neurons = nn;
    @(negedge i_clk); #1; i_start = 1'b1;
    @(negedge i_clk); #1; i_start = 1'b0;
    for (int i = 1; i < 3000 && done_cnt == 0; i++) begin
      @(negedge i_clk); #1;
      if (i == poke_at) begin
        i_start = 1'b1;
        i_in_base = ~ib; i_out_base = ~ob; i_w_base = ~wb;
        i_num_tiles = nt + 16'd1; i_num_neurons = nn + 16'd1;
      end else begin
        i_start = 1'b0;
      end
    end
    i_start = 1'b0;
    check("done seen within budget", done_cnt, 1);
    @(negedge i_clk); #1;
    check("busy low after done", o_busy, 0);
    check("single done", done_cnt, 1);
    check("pe_en count", pe_cnt, exp_pe);
    check("neuron_done count", nd_cnt, exp_nd);
    check("busy cycles", busy_cyc, exp_busy);
    check("rd queue drained", q_rd.size(), 0);
    check("sram queue drained", q_sram.size(), 0);
    check("wr queue drained", q_wr.size(), 0);
  endtask

  function automatic logic [63:0] all_outs();
    return {o_bram_rd, o_bram_rd_addr, o_sram_rd_req, o_sram_addr, o_pe_en, o_neuron_done,
            o_bram_wr, o_bram_wr_addr, o_busy, o_done};
  endfunction

  initial begin
    repeat (3) @(negedge i_clk);
    check("reset outputs zero", all_outs(), 0);
    i_reset = 1'b1;
    mon_en  = 1'b1;

    // Main layer: 2 tiles x 3 neurons, dval 2 cycles after request, relu 1 after close.
    build_expect(16'h10, 16'h40, 16'h100, 2, 3, 2, 1);
    check("model sram last", q_sram[5], 16'h105);
    check("model rd second", q_rd[1], 16'h11);
    check("model busy budget", exp_busy, 40);
    run_layer(16'h10, 16'h40, 16'h100, 16'd2, 16'd3, 2, 1, 0);
    check("busy cycles literal", busy_cyc, 40);
    check("write count", obs_wr.size(), 3);
    if (obs_wr.size() == 3) begin
      check("wr addr 0", obs_wr[0], 16'h40);
      check("wr addr 2", obs_wr[2], 16'h42);
    end
    check("rd addr 3", obs_rd.size() > 3 ? obs_rd[3] : 16'hdead, 16'h11);

    // Empty layers go straight to FIN.
    run_layer(16'h10, 16'h40, 16'h100, 16'd2, 16'd0, 2, 1, 0);
    check("zero neurons busy literal", busy_cyc, 1);
    run_layer(16'h10, 16'h40, 16'h100, 16'd0, 16'd3, 2, 1, 0);

    // Slow SRAM: dval 20 cycles after request.
    run_layer(16'h5, 16'h9, 16'h77, 16'd1, 16'd1, 20, 1, 0);
    check("slow sram busy literal", busy_cyc, 27);

    // Start pulse and config change mid-layer are ignored.
    run_layer(16'h200, 16'h300, 16'h20, 16'd2, 16'd2, 1, 3, 4);
    check("poke busy literal", busy_cyc, 27);

    // Input base wrap.
    run_layer(16'hFFFF, 16'h0, 16'h0, 16'd2, 16'd1, 1, 1, 0);
    check("wrap rd count", obs_rd.size(), 2);
    if (obs_rd.size() == 2) begin
      check("wrap rd 0", obs_rd[0], 16'hFFFF);
      check("wrap rd 1", obs_rd[1], 16'h0000);
    end

    // Reset during WAIT_R of neuron 1, then rerun from neuron 0.
    kw = 2; rw = 1;
    build_expect(16'h10, 16'h40, 16'h100, 2, 3, 2, 1);
    i_in_base = 16'h10; i_out_base = 16'h40; i_w_base = 16'h100;
    i_num_tiles = 16'd2; i_num_neurons = 16'd3;
    @(negedge i_clk); #1; i_start = 1'b1;
    @(negedge i_clk); #1; i_start = 1'b0;
    for (int i = 0; i < 500 && nd_cnt < 2; i++) begin
      @(negedge i_clk); #1;
    end
    relu_block = 1'b1;
    check("reached second close", nd_cnt, 2);
    @(negedge i_clk);
    check("waiting for relu", o_busy, 1);
    i_reset = 1'b0;
    @(negedge i_clk); #1;
    check("mid-layer reset outputs zero", all_outs(), 0);
    check("writes before reset", obs_wr.size(), 1);
    i_reset = 1'b1;
    relu_block = 1'b0;
    run_layer(16'h10, 16'h40, 16'h100, 16'd2, 16'd3, 2, 1, 0);
    check("rerun first write", obs_wr.size() > 0 ? obs_wr[0] : 16'hdead, 16'h40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
